wishbone_subordinate_regs: RTL and testbench



---
 rtl/wishbone_pkg.sv | 15 +
 rtl/wb_reg_bank.sv | 36 +++
 rtl/wishbone_subordinate_regs.sv | 119 +++++++++++
 tb/tb_wishbone_subordinate_regs.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone types and constants used by the subordinate register block.
package wishbone_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_sub_state_t;

  localparam logic [31:0] WB_UNMAPPED_DATA = 32'hDEAD_BEEF;
  localparam int          WB_WINDOW_WORDS  = 16;

  // One committed write into the register bank.
  typedef struct packed {
    logic        we;
    logic [3:0]  idx;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_wr_req_t;
endpackage

// File: rtl/wb_reg_bank.sv
// Bank of NUM_REGS 32-bit registers with byte-lane writes and per-register commit pulses.
module wb_reg_bank
  import wishbone_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  wb_wr_req_t                wr,
  output logic [NUM_REGS-1:0][31:0] regs,
  output logic [NUM_REGS-1:0]       wr_pulse
);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic        hit;
    logic [31:0] q;
    logic        pls;

    assign hit = wr.we && (wr.idx == 4'(g));

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        q   <= '0;
        pls <= 1'b0;
      end else begin
        pls <= hit;
        for (int k = 0; k < 4; k++)
          if (hit && wr.sel[k]) q[8*k +: 8] <= wr.dat[8*k +: 8];
      end
    end

    assign regs[g]     = q;
    assign wr_pulse[g] = pls;
  end

endmodule

// File: rtl/wishbone_subordinate_regs.sv
// Wishbone classic subordinate: window decode, wait-state FSM and register/status read mux.
module wishbone_subordinate_regs
  import wishbone_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [31:0]              ADR_I,
  input  logic [31:0]              DAT_I,
  input  logic [3:0]               SEL_I,
  input  logic                     WE_I,
  input  logic                     STB_I,
  input  logic                     CYC_I,
  output logic [31:0]              DAT_O,
  output logic                     ACK_O,
  output logic [32*NUM_REGS-1:0]   REGS_O,
  output logic [NUM_REGS-1:0]      WR_PULSE_O,
  input  logic [31:0]              STATUS_I
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [4:0] NREG      = 5'(NUM_REGS);

  wb_sub_state_t state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          enter_resp;

  logic [31:0]   offset, rdata;
  logic [3:0]    idx;
  logic          req, hit, is_reg, is_status;
  wb_wr_req_t    wr;
  logic [NUM_REGS-1:0][31:0] regs;

  // Unsigned wrap of the subtraction folds "below base" into "offset too large".
  assign offset    = ADR_I - BASE_ADDR;
  assign idx       = offset[5:2];
  assign req       = CYC_I & STB_I;
  assign hit       = req & (offset < 32'(4 * WB_WINDOW_WORDS));
  assign is_reg    = {1'b0, idx} < NREG;
  assign is_status = {1'b0, idx} == NREG;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE:
        if (hit) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      WAIT:
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          if (hit) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    rdata = WB_UNMAPPED_DATA;
    if (is_status) rdata = STATUS_I;
    for (int i = 0; i < NUM_REGS; i++)
      if ({1'b0, idx} == 5'(i)) rdata = regs[i];
  end

  // Bus fields are taken on the edge that enters RESP; the manager refreshes them every cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                   DAT_O <= '0;
    else if (enter_resp && !WE_I) DAT_O <= rdata;
    else                         DAT_O <= '0;
  end

  assign wr.we  = enter_resp & WE_I & is_reg;
  assign wr.idx = idx;
  assign wr.sel = SEL_I;
  assign wr.dat = DAT_I;

  wb_reg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
    .CLK      (CLK),
    .nRST     (nRST),
    .wr       (wr),
    .regs     (regs),
    .wr_pulse (WR_PULSE_O)
  );

  assign REGS_O = regs;
  assign ACK_O  = (state == RESP);

endmodule

// File: tb/tb_wishbone_subordinate_regs.sv
// Bench: two instances (1 and 3 wait states) share one bus; a register-array model predicts every response.
module tb_wishbone_subordinate_regs;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NR   = 8;

  logic CLK = 1'b0, nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] ADR_I = '0, DAT_I = '0, STATUS_I = '0;
  logic [3:0]  SEL_I = '0;
  logic        WE_I = 1'b0, STB_I = 1'b0, CYC_I = 1'b0;
  int          tgt = 0;
  logic        cyc1, cyc3;

  logic [31:0]        dat1, dat3, obs_dat;
  logic               ack1, ack3, obs_ack;
  logic [32*NR-1:0]   regs1, regs3;
  logic [NR-1:0]      pls1, pls3, obs_pls;

  assign cyc1    = CYC_I && (tgt == 0);
  assign cyc3    = CYC_I && (tgt == 1);
  assign obs_ack = tgt ? ack3 : ack1;
  assign obs_dat = tgt ? dat3 : dat1;
  assign obs_pls = tgt ? pls3 : pls1;

  wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .WE_I(WE_I),
    .STB_I(STB_I), .CYC_I(cyc1), .DAT_O(dat1), .ACK_O(ack1), .REGS_O(regs1),
    .WR_PULSE_O(pls1), .STATUS_I(STATUS_I));

  wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .WE_I(WE_I),
    .STB_I(STB_I), .CYC_I(cyc3), .DAT_O(dat3), .ACK_O(ack3), .REGS_O(regs3),
    .WR_PULSE_O(pls3), .STATUS_I(STATUS_I));

  logic [31:0] mdl [2][16];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int t, input int i);
    return t ? regs3[32*i +: 32] : regs1[32*i +: 32];
  endfunction

  function automatic logic [31:0] exp_read(input int t, input int idx);
    if (idx < NR)  return mdl[t][idx];
    if (idx == NR) return STATUS_I;
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk_regs(input int t);
    for (int i = 0; i < NR; i++) chk("regs", reg_of(t, i), mdl[t][i]);
  endtask

  task automatic clr_model();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 16; i++) mdl[t][i] = '0;
  endtask

  // One manager access: request held until ACK (or 10 cycles when outside the window).
  task automatic xfer(input int t, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0]   off, erd;
    logic [NR-1:0] epls;
    bit            inw;
    int            idx, w, got, lim;
    off = adr - BASE;
    inw = off < 32'd64;
    idx = inw ? int'(off[5:2]) : 0;
    w   = t ? 3 : 1;
    lim = inw ? w + 1 : 10;
    @(negedge CLK);
    tgt = t; ADR_I = adr; DAT_I = dat; SEL_I = sel; WE_I = we; CYC_I = 1'b1; STB_I = 1'b1;
    got = 0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge CLK);
      if (obs_ack) begin got = c; break; end
      chk("dat_pre", obs_dat, 32'h0);
    end
    if (inw) begin
      chk("ack_lat", 32'(got), 32'(w + 1));
      if (got != 0) begin
        erd  = exp_read(t, idx);
        epls = '0;
        if (we && idx < NR) begin
          for (int k = 0; k < 4; k++)
            if (sel[k]) mdl[t][idx][8*k +: 8] = dat[8*k +: 8];
          epls[idx] = 1'b1;
        end
        if (!we) chk("rdata", obs_dat, erd);
        chk("wr_pulse", 32'(obs_pls), 32'(epls));
      end
    end else begin
      chk("no_ack", 32'(got), 32'h0);
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK);
    chk("ack_drop", 32'(obs_ack), 32'h0);
    chk("dat_drop", obs_dat, 32'h0);
    chk("pls_drop", 32'(obs_pls), 32'h0);
    chk_regs(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int idx;
    logic [31:0] adr;
    clr_model();
    repeat (3) @(negedge CLK);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_dat1", dat1, 32'h0);
    chk("rst_pls1", 32'(pls1), 32'h0);
    chk("rst_ack3", 32'(ack3), 32'h0);
    chk_regs(0);
    chk_regs(1);
    nRST = 1'b1;

    // Full-word write, then byte-masked overwrite
    xfer(0, 1'b1, BASE + 32'd4, 32'h1234_5678, 4'hF);
    chk("reg1", reg_of(0, 1), 32'h1234_5678);
    xfer(0, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'hF);
    xfer(0, 1'b1, BASE + 32'd8, 32'h0000_0000, 4'b0101);
    chk("reg2_mask", reg_of(0, 2), 32'hFF00_FF00);
    xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'h3);

    // Status word, unmapped index, status write ignored
    STATUS_I = 32'hCAFE_0001;
    xfer(0, 1'b0, BASE + 32'(4 * NR), 32'h0, 4'hF);
    xfer(0, 1'b1, BASE + 32'(4 * NR), 32'h1111_1111, 4'hF);
    xfer(0, 1'b0, BASE + 32'd48, 32'h0, 4'hF);

    // Outside the window
    xfer(0, 1'b1, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF);
    xfer(0, 1'b1, BASE - 32'd4, 32'hA5A5_A5A5, 4'hF);
    xfer(1, 1'b0, BASE + 32'd64, 32'h0, 4'hF);

    // Abort mid-wait on the 3-wait-state instance
    @(negedge CLK);
    tgt = 1; ADR_I = BASE + 32'd12; DAT_I = 32'h55AA_55AA; SEL_I = 4'hF; WE_I = 1'b1;
    CYC_I = 1'b1; STB_I = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    STB_I = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (ack3) seen = 1'b1;
    end
    CYC_I = 1'b0; WE_I = 1'b0;
    chk("abort_ack", 32'(seen), 32'h0);
    chk_regs(1);
    xfer(1, 1'b1, BASE + 32'd12, 32'h55AA_55AA, 4'hF);

    // Reset asserted while waiting
    @(negedge CLK);
    tgt = 0; ADR_I = BASE + 32'd4; DAT_I = 32'h9999_8888; SEL_I = 4'hF; WE_I = 1'b1;
    CYC_I = 1'b1; STB_I = 1'b1;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    clr_model();
    chk("rstw_ack", 32'(ack1), 32'h0);
    chk_regs(0);
    chk_regs(1);
    @(negedge CLK);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk_regs(0);

    // Request held continuously: one-cycle ACKs every WAIT+2 cycles
    STATUS_I = 32'hCAFE_0001;
    @(negedge CLK);
    tgt = 0; ADR_I = BASE + 32'(4 * NR); SEL_I = 4'hF; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      chk("b2b_ack", 32'(ack1), 32'((c % 3) == 2));
      chk("b2b_dat", dat1, ((c % 3) == 2) ? 32'hCAFE_0001 : 32'h0);
    end
    CYC_I = 1'b0; STB_I = 1'b0;

    // Randomized traffic on both instances
    repeat (40) begin
      STATUS_I = $urandom;
      if ($urandom_range(0, 7) == 0)
        adr = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 8))
                                   : BASE + 32'd64 + 32'(4 * $urandom_range(0, 8));
      else begin
        idx = $urandom_range(0, 15);
        adr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      end
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
